// File: rtl/pq_pkg.sv
// Shared definitions for the heap priority-queue engine: command encodings,
// FSM state encoding and the single priority-compare function.
// Optional macro PQ_MIN_HEAP_EN selects a min-heap (smaller key wins);
// when it is undefined the engine is a max-heap (larger key wins).
package pq_pkg;

    localparam logic [2:0] CMD_BUILD    = 3'd0;
    localparam logic [2:0] CMD_EXTRACT  = 3'd1;
    localparam logic [2:0] CMD_INCREASE = 3'd2;
    localparam logic [2:0] CMD_INSERT   = 3'd3;
    localparam logic [2:0] CMD_WRITE    = 3'd4;

    // Keys are zero-extended to this width before comparing; DATA_WIDTH <= 64.
    localparam int PQ_KEY_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        BUILD_NEXT,
        SD_CMP,
        SD_SWAP,
        SU_CMP,
        SU_SWAP,
        DUMP,
        FINISH
    } pq_state_e;

    // True when key a must sit above key b in the heap. Equal keys are never
    // "higher", which is what makes the parent win ties during sifting.
    function automatic logic higher_prio(input logic [PQ_KEY_W-1:0] a,
                                         input logic [PQ_KEY_W-1:0] b);
`ifdef PQ_MIN_HEAP_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

endpackage

// File: rtl/pq_heap_engine_if.sv
// Command/load/result bundle between the command source (master) and the
// heap engine (slave).
interface pq_heap_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
);
    localparam int AW = $clog2(DEPTH);

    logic                  data_valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  cmd_valid;
    logic [2:0]            cmd;
    logic [AW-1:0]         index;
    logic [DATA_WIDTH-1:0] value;
    logic                  busy;
    logic                  RAM_valid;
    logic [AW-1:0]         RAM_A;
    logic [DATA_WIDTH-1:0] RAM_D;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [AW:0]           count;
    logic                  done;
    logic                  err;

    modport master (
        output data_valid, data, cmd_valid, cmd, index, value,
        input  busy, RAM_valid, RAM_A, RAM_D, out_valid, out_data, count, done, err
    );

    modport slave (
        input  data_valid, data, cmd_valid, cmd, index, value,
        output busy, RAM_valid, RAM_A, RAM_D, out_valid, out_data, count, done, err
    );

endinterface

// File: rtl/pq_heap_regfile.sv
// Heap key storage: three combinational read ports (node, left, right) and
// two write ports. Port A is applied last so it wins an address collision.
module pq_heap_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [AW-1:0]         rd_p_addr,
    input  logic [AW-1:0]         rd_l_addr,
    input  logic [AW-1:0]         rd_r_addr,
    output logic [DATA_WIDTH-1:0] rd_p_data,
    output logic [DATA_WIDTH-1:0] rd_l_data,
    output logic [DATA_WIDTH-1:0] rd_r_data,
    input  logic                  we_a,
    input  logic [AW-1:0]         wa_a,
    input  logic [DATA_WIDTH-1:0] wd_a,
    input  logic                  we_b,
    input  logic [AW-1:0]         wa_b,
    input  logic [DATA_WIDTH-1:0] wd_b
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write B first, then A, so A overrides B on the same address.
    always_ff @(posedge clk) begin
        if (we_b) mem[wa_b] <= wd_b;
        if (we_a) mem[wa_a] <= wd_a;
    end

    assign rd_p_data = mem[rd_p_addr];
    assign rd_l_data = mem[rd_l_addr];
    assign rd_r_data = mem[rd_r_addr];

endmodule

// File: rtl/pq_heap_engine.sv
// Binary-heap priority queue engine: raw load, BUILD, EXTRACT, INSERT,
// INCREASE and WRITE (RAM dump) commands driven by one FSM.
// PQ_MIN_HEAP_EN (see pq_pkg) switches the heap from max to min ordering.
module pq_heap_engine
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic clk,
    input  logic rst,
    pq_heap_engine_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    pq_state_e             state_reg;
    logic                  busy_reg, ram_valid_reg, out_valid_reg, done_reg, err_reg;
    logic [AW-1:0]         ram_a_reg;
    logic [DATA_WIDTH-1:0] ram_d_reg, out_data_reg;
    logic [AW:0]           count_reg, dump_reg;
    logic [AW-1:0]         node_reg, build_reg, win_reg;
    logic                  win_right_reg, is_build_reg;

    logic [AW-1:0]         rd_p_addr, rd_l_addr, rd_r_addr;
    logic [DATA_WIDTH-1:0] rd_p_data, rd_l_data, rd_r_data;
    logic                  we_a, we_b;
    logic [AW-1:0]         wa_a, wa_b;
    logic [DATA_WIDTH-1:0] wd_a, wd_b;

    logic [AW+1:0]         left_idx, right_idx, cnt_ext;
    logic [AW-1:0]         su_parent, count_m1, build_start, sd_best;
    logic [DATA_WIDTH-1:0] best_key;
    logic                  sd_best_right, sd_stay, su_swap, idx_ok, incr_ok;

    function automatic logic prio(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b);
        return higher_prio(PQ_KEY_W'(a), PQ_KEY_W'(b));
    endfunction

    pq_heap_regfile #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_regfile (
        .clk(clk),
        .rd_p_addr(rd_p_addr), .rd_l_addr(rd_l_addr), .rd_r_addr(rd_r_addr),
        .rd_p_data(rd_p_data), .rd_l_data(rd_l_data), .rd_r_data(rd_r_data),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b)
    );

    // Child indices carry two extra bits so 2i+2 never wraps at DEPTH-1.
    assign left_idx    = {1'b0, node_reg, 1'b1};
    assign right_idx   = left_idx + (AW+2)'(1);
    assign cnt_ext     = {1'b0, count_reg};
    assign su_parent   = (node_reg - AW'(1)) >> 1;
    assign count_m1    = count_reg[AW-1:0] - AW'(1);
    assign build_start = count_reg[AW:1] - AW'(1);
    assign idx_ok      = {1'b0, bus.index} < count_reg;
    assign incr_ok     = prio(bus.value, rd_p_data);
    assign su_swap     = (node_reg != '0) && prio(rd_l_data, rd_p_data);

    // Read-port steering: IDLE looks at root/last/INCREASE target, sift
    // states look at the current node and its neighbours, DUMP walks slots.
    always_comb begin
        rd_p_addr = '0;
        rd_l_addr = '0;
        rd_r_addr = '0;
        case (state_reg)
            IDLE: begin
                rd_p_addr = (bus.cmd == CMD_INCREASE) ? bus.index : '0;
                rd_l_addr = count_m1;
            end
            SD_CMP, SD_SWAP: begin
                rd_p_addr = node_reg;
                rd_l_addr = left_idx[AW-1:0];
                rd_r_addr = right_idx[AW-1:0];
            end
            SU_CMP, SU_SWAP: begin
                rd_p_addr = su_parent;
                rd_l_addr = node_reg;
            end
            DUMP: rd_p_addr = dump_reg[AW-1:0];
            default: ;
        endcase
    end

    // Sift-down winner among node and in-range children; parent wins ties,
    // left wins a tie between children.
    always_comb begin
        best_key      = rd_p_data;
        sd_best       = node_reg;
        sd_best_right = 1'b0;
        sd_stay       = 1'b1;
        if (left_idx < cnt_ext && prio(rd_l_data, best_key)) begin
            best_key = rd_l_data;
            sd_best  = left_idx[AW-1:0];
            sd_stay  = 1'b0;
        end
        if (right_idx < cnt_ext && prio(rd_r_data, best_key)) begin
            best_key      = rd_r_data;
            sd_best       = right_idx[AW-1:0];
            sd_best_right = 1'b1;
            sd_stay       = 1'b0;
        end
    end

    // Storage writes: B for load/insert/extract/increase and the lower half
    // of a swap, A for the upper half of a swap.
    always_comb begin
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd == CMD_EXTRACT && count_reg != '0) begin
                        we_b = 1'b1; wa_b = '0; wd_b = rd_l_data;
                    end else if (bus.cmd == CMD_INSERT && count_reg != FULL_CNT) begin
                        we_b = 1'b1; wa_b = count_reg[AW-1:0]; wd_b = bus.value;
                    end else if (bus.cmd == CMD_INCREASE && idx_ok && incr_ok) begin
                        we_b = 1'b1; wa_b = bus.index; wd_b = bus.value;
                    end
                end else if (bus.data_valid && count_reg != FULL_CNT) begin
                    we_b = 1'b1; wa_b = count_reg[AW-1:0]; wd_b = bus.data;
                end
            end
            SD_SWAP: begin
                we_a = 1'b1; wa_a = node_reg; wd_a = win_right_reg ? rd_r_data : rd_l_data;
                we_b = 1'b1; wa_b = win_reg;  wd_b = rd_p_data;
            end
            SU_SWAP: begin
                we_a = 1'b1; wa_a = su_parent; wd_a = rd_l_data;
                we_b = 1'b1; wa_b = node_reg;  wd_b = rd_p_data;
            end
            default: ;
        endcase
    end

    // Main control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            ram_valid_reg <= 1'b0;
            ram_a_reg     <= '0;
            ram_d_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            count_reg     <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            node_reg      <= '0;
            build_reg     <= '0;
            win_reg       <= '0;
            win_right_reg <= 1'b0;
            dump_reg      <= '0;
            is_build_reg  <= 1'b0;
        end else begin
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            ram_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        busy_reg     <= 1'b1;
                        err_reg      <= bus.data_valid;  // simultaneous load word is dropped
                        is_build_reg <= (bus.cmd == CMD_BUILD);
                        case (bus.cmd)
                            CMD_BUILD: begin
                                if (count_reg <= ONE_CNT) begin
                                    state_reg <= FINISH; busy_reg <= 1'b0; done_reg <= 1'b1;
                                end else begin
                                    build_reg <= build_start;
                                    node_reg  <= build_start;
                                    state_reg <= SD_CMP;
                                end
                            end
                            CMD_EXTRACT: begin
                                if (count_reg == '0) begin
                                    state_reg <= FINISH; busy_reg <= 1'b0; done_reg <= 1'b1; err_reg <= 1'b1;
                                end else begin
                                    out_data_reg  <= rd_p_data;
                                    out_valid_reg <= 1'b1;
                                    count_reg     <= count_reg - ONE_CNT;
                                    node_reg      <= '0;
                                    state_reg     <= SD_CMP;
                                end
                            end
                            CMD_INSERT: begin
                                if (count_reg == FULL_CNT) begin
                                    state_reg <= FINISH; busy_reg <= 1'b0; done_reg <= 1'b1; err_reg <= 1'b1;
                                end else begin
                                    count_reg <= count_reg + ONE_CNT;
                                    node_reg  <= count_reg[AW-1:0];
                                    state_reg <= SU_CMP;
                                end
                            end
                            CMD_INCREASE: begin
                                if (!idx_ok) begin
                                    state_reg <= FINISH; busy_reg <= 1'b0; done_reg <= 1'b1; err_reg <= 1'b1;
                                end else if (!incr_ok) begin
                                    state_reg <= FINISH; busy_reg <= 1'b0; done_reg <= 1'b1;
                                end else begin
                                    node_reg  <= bus.index;
                                    state_reg <= SU_CMP;
                                end
                            end
                            CMD_WRITE: begin
                                dump_reg  <= '0;
                                state_reg <= DUMP;
                            end
                            default: begin
                                state_reg <= FINISH; busy_reg <= 1'b0; done_reg <= 1'b1; err_reg <= 1'b1;
                            end
                        endcase
                    end else if (bus.data_valid) begin
                        if (count_reg == FULL_CNT) err_reg <= 1'b1;
                        else                       count_reg <= count_reg + ONE_CNT;
                    end
                end
                SD_CMP: begin
                    if (sd_stay) begin
                        if (is_build_reg) begin
                            state_reg <= BUILD_NEXT;
                        end else begin
                            state_reg <= FINISH; busy_reg <= 1'b0; done_reg <= 1'b1;
                        end
                    end else begin
                        win_reg       <= sd_best;
                        win_right_reg <= sd_best_right;
                        state_reg     <= SD_SWAP;
                    end
                end
                SD_SWAP: begin
                    node_reg  <= win_reg;
                    state_reg <= SD_CMP;
                end
                BUILD_NEXT: begin
                    if (build_reg == '0) begin
                        state_reg <= FINISH; busy_reg <= 1'b0; done_reg <= 1'b1;
                    end else begin
                        build_reg <= build_reg - AW'(1);
                        node_reg  <= build_reg - AW'(1);
                        state_reg <= SD_CMP;
                    end
                end
                SU_CMP: begin
                    if (su_swap) begin
                        state_reg <= SU_SWAP;
                    end else begin
                        state_reg <= FINISH; busy_reg <= 1'b0; done_reg <= 1'b1;
                    end
                end
                SU_SWAP: begin
                    node_reg  <= su_parent;
                    state_reg <= SU_CMP;
                end
                DUMP: begin
                    if (dump_reg < count_reg) begin
                        ram_valid_reg <= 1'b1;
                        ram_a_reg     <= dump_reg[AW-1:0];
                        ram_d_reg     <= rd_p_data;
                        dump_reg      <= dump_reg + ONE_CNT;
                    end else begin
                        state_reg <= FINISH; busy_reg <= 1'b0; done_reg <= 1'b1;
                    end
                end
                FINISH:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.RAM_valid = ram_valid_reg;
    assign bus.RAM_A     = ram_a_reg;
    assign bus.RAM_D     = ram_d_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.count     = count_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_pq_heap_engine.sv
// Scoreboard bench for pq_heap_engine: stimulus pushes expected extract keys,
// RAM dump words and done/err events; a monitor pops and compares them.
module tb_pq_heap_engine;
    import pq_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pq_heap_engine_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    pq_heap_engine #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]    exp_out_q [$];
    logic [AW+DW-1:0] exp_ram_q [$];
    logic [1:0]       exp_evt_q [$];   // {done, err}

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    initial begin : monitor
        logic [DW-1:0]    eo;
        logic [AW+DW-1:0] er;
        logic [1:0]       ee;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.out_valid) begin
                    if (exp_out_q.size() == 0) check("unexpected out_valid", 1, 0);
                    else begin
                        eo = exp_out_q.pop_front();
                        $display("extract: out_data=%0d expected=%0d", bus.out_data, eo);
                        check("out_data", int'(bus.out_data), int'(eo));
                    end
                end
                if (bus.RAM_valid) begin
                    if (exp_ram_q.size() == 0) check("unexpected RAM_valid", 1, 0);
                    else begin
                        er = exp_ram_q.pop_front();
                        $display("dump: RAM_A=%0d RAM_D=%0d expected %0d/%0d",
                                 bus.RAM_A, bus.RAM_D, er[AW+DW-1:DW], er[DW-1:0]);
                        check("RAM_A", int'(bus.RAM_A), int'(er[AW+DW-1:DW]));
                        check("RAM_D", int'(bus.RAM_D), int'(er[DW-1:0]));
                    end
                end
                if (bus.done || bus.err) begin
                    if (exp_evt_q.size() == 0) check("unexpected done/err", 1, 0);
                    else begin
                        ee = exp_evt_q.pop_front();
                        $display("event: done=%0d err=%0d expected %0d/%0d", bus.done, bus.err, ee[1], ee[0]);
                        check("done", int'(bus.done), int'(ee[1]));
                        check("err", int'(bus.err), int'(ee[0]));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] v);
        bus.data_valid = 1'b1;
        bus.data       = v;
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
    endtask

    task automatic load_list(input logic [DW-1:0] vals [$]);
        foreach (vals[k]) load(vals[k]);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = bus.done;
        end
        check("done within cycle budget", int'(seen), 1);
        @(posedge clk); #1;
    endtask

    task automatic run_cmd(input logic [2:0] c, input logic [AW-1:0] idx,
                           input logic [DW-1:0] val, input logic exp_err);
        exp_evt_q.push_back({1'b1, exp_err});
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.index     = idx;
        bus.value     = val;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        wait_done();
    endtask

    task automatic expect_dump(input logic [DW-1:0] vals [$]);
        foreach (vals[k]) exp_ram_q.push_back({AW'(k), vals[k]});
        run_cmd(CMD_WRITE, '0, '0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.data_valid = 1'b0; bus.data  = '0;
        bus.cmd_valid  = 1'b0; bus.cmd   = '0;
        bus.index      = '0;   bus.value = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy",      int'(bus.busy),      0);
        check("reset RAM_valid", int'(bus.RAM_valid), 0);
        check("reset RAM_A",     int'(bus.RAM_A),     0);
        check("reset RAM_D",     int'(bus.RAM_D),     0);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_data",  int'(bus.out_data),  0);
        check("reset count",     int'(bus.count),     0);
        check("reset done",      int'(bus.done),      0);
        check("reset err",       int'(bus.err),       0);
        rst = 1'b0;

        // Extract on an empty heap: err+done, no out_valid.
        run_cmd(CMD_EXTRACT, '0, '0, 1'b1);
        check("count after empty extract", int'(bus.count), 0);

`ifndef PQ_MIN_HEAP_EN
        // Build and dump.
        load_list('{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6});
        check("count after 8 loads", int'(bus.count), 8);
        run_cmd(CMD_BUILD, '0, '0, 1'b0);
        expect_dump('{8'd9, 8'd6, 8'd4, 8'd1, 8'd5, 8'd3, 8'd2, 8'd1});
        check("count after build", int'(bus.count), 8);

        // Three extracts.
        exp_out_q.push_back(8'd9); run_cmd(CMD_EXTRACT, '0, '0, 1'b0);
        exp_out_q.push_back(8'd6); run_cmd(CMD_EXTRACT, '0, '0, 1'b0);
        exp_out_q.push_back(8'd5); run_cmd(CMD_EXTRACT, '0, '0, 1'b0);
        check("count after 3 extracts", int'(bus.count), 5);
        expect_dump('{8'd4, 8'd2, 8'd3, 8'd1, 8'd1});

        // Insert then increase.
        do_reset();
        load_list('{8'd9, 8'd6, 8'd4});
        run_cmd(CMD_INSERT, '0, 8'd7, 1'b0);
        run_cmd(CMD_INCREASE, 4'd2, 8'd8, 1'b0);
        expect_dump('{8'd9, 8'd7, 8'd8, 8'd6});
        check("count after insert", int'(bus.count), 4);

        // Increase not higher: no change, no err. Out-of-range index: err.
        do_reset();
        load_list('{8'd9, 8'd6});
        run_cmd(CMD_INCREASE, 4'd1, 8'd0, 1'b0);
        run_cmd(CMD_INCREASE, 4'd5, 8'd50, 1'b1);
        expect_dump('{8'd9, 8'd6});
`endif

        // Illegal command: err + done, count unchanged.
        do_reset();
        load_list('{8'd11, 8'd22});
        run_cmd(3'd5, '0, '0, 1'b1);
        check("count after illegal cmd", int'(bus.count), 2);

        // Fill to capacity, then overflow by load and by INSERT.
        do_reset();
        for (int k = 0; k < DEPTH; k++) load(DW'(k + 1));
        check("count full", int'(bus.count), DEPTH);
        exp_evt_q.push_back(2'b01);
        load(8'd99);
        check("count after overflow load", int'(bus.count), DEPTH);
        run_cmd(CMD_INSERT, '0, 8'd50, 1'b1);
        check("count after overflow insert", int'(bus.count), DEPTH);

        // Reset in the middle of a BUILD sift aborts without done.
        do_reset();
        load_list('{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6});
        bus.cmd_valid = 1'b1; bus.cmd = CMD_BUILD;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy during build", int'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("busy after mid-build reset",  int'(bus.busy),  0);
        check("count after mid-build reset", int'(bus.count), 0);
        check("done after mid-build reset",  int'(bus.done),  0);
        rst = 1'b0;

        // Small build + extract: root depends on heap ordering mode.
        load_list('{8'd3, 8'd1, 8'd2});
        run_cmd(CMD_BUILD, '0, '0, 1'b0);
`ifdef PQ_MIN_HEAP_EN
        exp_out_q.push_back(8'd1);
`else
        exp_out_q.push_back(8'd3);
`endif
        run_cmd(CMD_EXTRACT, '0, '0, 1'b0);
        check("count after small extract", int'(bus.count), 2);

        repeat (5) @(posedge clk);
        #1;
        check("pending extract expectations", exp_out_q.size(), 0);
        check("pending dump expectations",    exp_ram_q.size(), 0);
        check("pending event expectations",   exp_evt_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pq_heap_engine.md
# pq_heap_engine

Parametrised binary-heap priority queue engine; successor to the hw4 8-bit max-queue block. Adds configurable width/depth, sift-up for insert/increase, an extract result port, full/empty/index error reporting and an optional min-heap mode. Sits between the stimulus/command source and the result RAM writer, and reuses the same command encodings and RAM-dump handshake.

## Interface
- DATA_WIDTH, 8, key width in bits.
- DEPTH, 256, heap capacity in entries; power of two, 4..1024.
- AW (localparam), $clog2(DEPTH), index/address width.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset; synchronous and active-high.
- data_valid  in  1  raw-load strobe: append `data` without reordering.
- data  in  DATA_WIDTH  raw-load key.
- cmd_valid  in  1  command strobe.
- cmd  in  3  0 BUILD, 1 EXTRACT, 2 INCREASE, 3 INSERT, 4 WRITE; 5-7 illegal.
- index  in  AW  target slot for INCREASE.
- value  in  DATA_WIDTH  key for INCREASE/INSERT.
- busy  out  1  command in progress; inputs ignored while high.
- RAM_valid  out  1  RAM_A/RAM_D valid this cycle.
- RAM_A  out  AW  dump address.
- RAM_D  out  DATA_WIDTH  dump data.
- out_valid  out  1  one-cycle pulse with extracted key.
- out_data  out  DATA_WIDTH  extracted root key, held until next extract.
- count  out  AW+1  current entry count.
- done  out  1  one-cycle pulse at completion of every accepted command.
- err  out  1  one-cycle pulse, same cycle as done, on a rejected command or load.

## Operation
- Reset values: busy 0, RAM_valid 0, RAM_A 0, RAM_D 0, out_valid 0, out_data 0, count 0, done 0, err 0, FSM IDLE. Heap storage is not cleared; contents are don't-care.
- Reset mid-command aborts immediately, with no done pulse.
- IDLE, cmd_valid=1: latch cmd/index/value, busy=1 next cycle. cmd_valid wins over a simultaneous data_valid; the data word is dropped and err pulses.
- IDLE, data_valid only: heap[count]<=data, count++. If count==DEPTH, the word is dropped and err pulses. done does not pulse for loads.
- BUILD: i = count/2-1 down to 0, sift-down each i. With count<=1 it completes at once.
- EXTRACT:
  - out_data<=heap[0], out_valid pulses.
  - heap[0]<=heap[count-1], count--, then sift-down from 0.
  - count==0: err, no change.
- INSERT:
  - heap[count]<=value, count++, then sift-up from the new slot.
  - count==DEPTH: err, no change.
- INCREASE:
  - index>=count: err.
  - value not higher priority than heap[index]: no change and no err.
  - Otherwise heap[index]<=value, then sift-up.
- WRITE: RAM_valid=1 for `count` consecutive cycles, with RAM_A=0..count-1 and RAM_D=heap[RAM_A]. With count==0 there are no RAM cycles.
- Illegal cmd: err + done, no change.
- States: IDLE, BUILD_NEXT, SD_CMP, SD_SWAP, SU_CMP, SU_SWAP, DUMP, FINISH. FINISH drives done/err and busy=0, then returns to IDLE.
- SD_CMP picks the highest-priority of {i, 2i+1, 2i+2} among slots < count.
  - Equal keys never swap; the parent wins ties.
  - If the winner is i, go to BUILD_NEXT (BUILD) or FINISH (others).
  - Otherwise go to SD_SWAP: exchange, set i=winner, return to SD_CMP.
- SU_CMP compares slot i with parent (i-1)>>1.
  - If the child has strictly higher priority, go to SU_SWAP; otherwise go to FINISH.
  - i==0 goes to FINISH.
- Child indices are computed at AW+2 bits, so no wrap occurs at DEPTH-1. Keys compare unsigned.

## Timing
- Command sampled at edge N: busy=1 from N+1 until the FINISH cycle, inclusive of busy=0 in that cycle. done/err are high in FINISH only.
- A new command is accepted in the cycle after FINISH at the earliest.
- Sift step = 2 cycles (CMP+SWAP). A terminating CMP costs 1 cycle.
- EXTRACT/INSERT/INCREASE worst case: 2 + 2·log2(DEPTH) cycles.
- out_valid pulses in the first busy cycle of EXTRACT.
- WRITE: first RAM_valid in cycle N+2, last in N+1+count, then FINISH.
- count updates the cycle after the load or the INSERT/EXTRACT entry cycle.

## Configuration
- PQ_MIN_HEAP_EN defined: min-heap. Priority = smaller key.
  - INCREASE is accepted only if value < heap[index].
  - EXTRACT returns the minimum.
- Undefined: max-heap. Priority = larger key; INCREASE requires value > heap[index].
- Only the single priority-compare function changes between modes.

## Structure
- Package pq_pkg: command encodings (CMD_BUILD..CMD_WRITE), FSM state enum, and the `higher_prio(a,b)` compare function guarded by PQ_MIN_HEAP_EN.
- Sub-module pq_heap_regfile holds the DEPTH×DATA_WIDTH storage.
  - Three asynchronous read ports: parent, left, right.
  - Two synchronous write ports, for the swap and load/insert writes.
  - When both write ports target the same address, port A wins.

## Test plan
- Load 3,1,4,1,5,9,2,6; BUILD; WRITE: RAM stream 9,6,4,1,5,3,2,1 with RAM_A 0..7, one done pulse, count=8.
- After BUILD, EXTRACT ×3: out_data 9,6,5; count 5; WRITE yields a valid max-heap.
- INSERT 7 into {9,6,4}; then INCREASE index=2 value=8: WRITE gives 9,7,8,6.
- INCREASE index=1 value 0 on {9,6}: no change, err=0. INCREASE index=5 with count 2: err=1.
- EXTRACT on empty: err+done, out_valid=0. Fill DEPTH entries, then load or INSERT one more: err, count stays DEPTH.
- Assert rst during a BUILD sift: next cycle busy=0, count=0, no done. Rerun with PQ_MIN_HEAP_EN: load 3,1,2 + BUILD + EXTRACT gives out_data 1.
